// File: rtl/ctrl_multicycle.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over a shared
// memory port with a mem_ready wait-state handshake and a sticky illegal halt.
module ctrl_multicycle #(
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter bit SUPPORT_JAL   = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        adr_src,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_src,
  output logic        illegal,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_ok;
  logic       en_pc, en_ir, en_reg, en_rd, en_wr;
  logic       unused;

  assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign unused = ^{instruction[31:15], instruction[11:7]};
  assign br_ok  = (funct3 == 3'b000) || (SUPPORT_BNE && funct3 == 3'b001);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE)   state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                   state_d = S_EXECR;
        else if (opcode == OP_ITYPE)                   state_d = S_EXECI;
        else if (opcode == OP_BRANCH && br_ok)         state_d = S_BRANCH;
        else if (opcode == OP_JAL && SUPPORT_JAL)      state_d = S_JAL;
        else begin
          state_d   = S_ILLEGAL;
          illegal_d = 1'b1;
        end
      end
      // opcode bit 5 separates SW from LW
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    en_pc      = 1'b0;
    en_ir      = 1'b0;
    en_reg     = 1'b0;
    en_rd      = 1'b0;
    en_wr      = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        en_rd      = 1'b1;
        en_ir      = ready;
        en_pc      = ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        en_rd   = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        en_reg     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        en_wr   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:  en_reg = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        en_pc     = funct3[0] ? ~zero : zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        en_pc     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low while reset is held so no write escapes mid-reset
  assign pc_write  = en_pc  & ~rst;
  assign ir_write  = en_ir  & ~rst;
  assign reg_write = en_reg & ~rst;
  assign mem_read  = en_rd  & ~rst;
  assign mem_write = en_wr  & ~rst;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

  always_comb begin
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_ctrl_multicycle.sv
// Directed bench for ctrl_multicycle: walks each instruction class through the
// FSM with hand-computed state/enable expectations, plus a reduced-feature copy.
module tb_ctrl_multicycle;
  logic        clk, rst, zero, mem_ready;
  logic [31:0] instruction;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0]  state_dbg;
  logic        pc_write2, ir_write2, reg_write2, mem_read2, mem_write2, adr_src2, illegal2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2, alu_op2, imm_src2;
  logic [3:0]  state_dbg2;
  logic [5:0]  ctl;
  int          errs = 0, checks = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h00002083;
  localparam logic [31:0] I_SW  = 32'h00102023;
  localparam logic [31:0] I_BEQ = 32'h00000063;
  localparam logic [31:0] I_BNE = 32'h00001063;
  localparam logic [31:0] I_JAL = 32'h0000006F;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  assign ctl = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src};

  ctrl_multicycle dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .adr_src(adr_src), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  ctrl_multicycle #(.SUPPORT_BNE(1'b0), .SUPPORT_JAL(1'b0), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write2), .ir_write(ir_write2), .reg_write(reg_write2), .mem_read(mem_read2),
    .mem_write(mem_write2), .adr_src(adr_src2), .result_src(result_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .alu_op(alu_op2), .imm_src(imm_src2), .illegal(illegal2),
    .state_dbg(state_dbg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctl order: pc_write ir_write reg_write mem_read mem_write adr_src
  task automatic st(input string tag, input logic [3:0] s, input logic [5:0] c);
    #1;
    chk({tag, "_state"}, 32'(state_dbg), 32'(s));
    chk({tag, "_ctl"}, 32'(ctl), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_br(input string tag, input logic [31:0] ins, input logic z, input logic pcw);
    instruction = ins; zero = z; mem_ready = 1'b1;
    st({tag, "_f"}, 4'd0, 6'b110100); tick();
    st({tag, "_d"}, 4'd1, 6'b000000); tick();
    st({tag, "_b"}, 4'd9, {pcw, 5'b00000});
    chk({tag, "_op"}, 32'(alu_op), 32'd1);
    tick();
    st({tag, "_ret"}, 4'd0, 6'b110100);
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; instruction = I_ADD;
    tick();
    st("rst", 4'd0, 6'b000000);
    chk("rst_srcb", 32'(alu_src_b), 32'd2);
    chk("rst_ressrc", 32'(result_src), 32'd2);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;

    // ADD: 0,1,6,8
    st("add_f", 4'd0, 6'b110100); tick();
    st("add_d", 4'd1, 6'b000000);
    chk("add_d_srca", 32'(alu_src_a), 32'd1);
    tick();
    st("add_ex", 4'd6, 6'b000000);
    chk("add_ex_op", 32'(alu_op), 32'd2);
    tick();
    st("add_wb", 4'd8, 6'b001000); tick();
    st("add_ret", 4'd0, 6'b110100);

    // LW with three wait states in MEMREAD
    instruction = I_LW;
    tick(); tick();
    st("lw_adr", 4'd2, 6'b000000);
    chk("lw_adr_srca", 32'(alu_src_a), 32'd2);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st("lw_wait", 4'd3, 6'b000101); tick();
    end
    mem_ready = 1'b1;
    st("lw_rd", 4'd3, 6'b000101); tick();
    st("lw_wb", 4'd4, 6'b001000);
    chk("lw_wb_ressrc", 32'(result_src), 32'd1);
    tick();
    st("lw_ret", 4'd0, 6'b110100);

    // SW with two wait states
    instruction = I_SW;
    #1 chk("sw_imm", 32'(imm_src), 32'd1);
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st("sw_wait", 4'd5, 6'b000011); tick();
    end
    mem_ready = 1'b1;
    st("sw_wr", 4'd5, 6'b000011); tick();
    st("sw_ret", 4'd0, 6'b110100);

    run_br("bne_z0", I_BNE, 1'b0, 1'b1);
    run_br("bne_z1", I_BNE, 1'b1, 1'b0);
    run_br("beq_z1", I_BEQ, 1'b1, 1'b1);
    run_br("beq_z0", I_BEQ, 1'b0, 1'b0);

    // JAL: 0,1,10,8
    instruction = I_JAL;
    tick(); tick();
    st("jal", 4'd10, 6'b100000);
    chk("jal_srcb", 32'(alu_src_b), 32'd2);
    chk("jal_imm", 32'(imm_src), 32'd3);
    tick();
    st("jal_wb", 4'd8, 6'b001000); tick();
    st("jal_ret", 4'd0, 6'b110100);

    // Reduced-feature copy: BNE illegal, mem_ready ignored
    rst = 1'b1; #1 rst = 1'b0;
    instruction = I_BNE; mem_ready = 1'b0;
    st("stall_f", 4'd0, 6'b000100);
    chk("nb_f", 32'(state_dbg2), 32'd0);
    tick();
    st("stall_f2", 4'd0, 6'b000100);
    chk("nb_dec", 32'(state_dbg2), 32'd1);
    tick();
    chk("nb_state", 32'(state_dbg2), 32'd11);
    chk("nb_illegal", 32'(illegal2), 32'd1);
    chk("bne_ok_illegal", 32'(illegal), 32'd0);

    // Illegal opcode halts for good
    rst = 1'b1; #1 rst = 1'b0;
    instruction = I_BAD; mem_ready = 1'b1;
    st("ill_f", 4'd0, 6'b110100); tick();
    st("ill_d", 4'd1, 6'b000000);
    chk("ill_d_flag", 32'(illegal), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      st("ill_hold", 4'd11, 6'b000000);
      chk("ill_flag", 32'(illegal), 32'd1);
      tick();
    end
    rst = 1'b1;
    st("ill_rst", 4'd0, 6'b000000);
    chk("ill_rst_flag", 32'(illegal), 32'd0);
    rst = 1'b0; instruction = I_ADD;
    st("ill_refetch", 4'd0, 6'b110100); tick();
    st("ill_redec", 4'd1, 6'b000000); tick();
    st("ill_reex", 4'd6, 6'b000000);

    // Reset mid-MEMREAD drops the access
    rst = 1'b1; #1 rst = 1'b0;
    instruction = I_LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    st("mr_rd", 4'd3, 6'b000101);
    rst = 1'b1;
    st("mr_rst", 4'd0, 6'b000000); tick();
    st("mr_rst_hold", 4'd0, 6'b000000);
    rst = 1'b0; mem_ready = 1'b1; instruction = I_ADD;
    st("mr_fetch", 4'd0, 6'b110100); tick();
    st("mr_dec", 4'd1, 6'b000000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
